uart_rx_sm: RTL

//  - Async serial receiver; consumes CE_16x from UART_BRG (16x oversample enable).
//  - Frame: start bit, 7 or 8 data bits LSB first, optional parity, 1 stop bit.
//  - Delivers bytes through a one-deep holding register with a read handshake, plus error flags.
//  - Sits beside the UART transmitter, driven by the same UART_BRG instance.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_rx_sync.sv | 47 ++++
 rtl/uart_rx_sm.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state codes, majority-sample tick positions and the
// data-length encoding. Receiver parity is built only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_START = 3'd1;
   localparam logic [2:0] ST_DATA  = 3'd2;
   localparam logic [2:0] ST_PAR   = 3'd3;
   localparam logic [2:0] ST_STOP  = 3'd4;
   localparam logic [2:0] ST_WAIT  = 3'd5;

   // Three samples are taken at SAMPLE_BASE, +1 and +2; the vote happens on the last one.
   localparam int SAMPLE_BASE     = 7;
   localparam int SAMPLE_VOTE_OFS = 2;

   localparam logic LEN_8 = 1'b0;
   localparam logic LEN_7 = 1'b1;

   typedef struct packed {
      logic [7:0] data;
      logic       fe;
      logic       brk;
   } rx_frame_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [3:0] last_data_idx(input logic len);
      return (len == LEN_7) ? 4'd6 : 4'd7;
   endfunction

   function automatic logic [2:0] state_after_data(input logic par_en);
      return par_en ? ST_PAR : ST_STOP;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// RxD synchronizer chain plus 3-sample majority filter for the UART receiver
// (shared by both builds, with or without UART_RX_PARITY_EN).
module uart_rx_sync
   import uart_pkg::*;
#(
   parameter int pSyncStages = 2,
   parameter int pSampleBase = SAMPLE_BASE
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic       ce_16x,
   input  logic       rxd,
   input  logic [3:0] phase,
   output logic       rx_sync,
   output logic       smp_vld,
   output logic       smp_bit
);

   localparam logic [3:0] TickA = 4'(pSampleBase);
   localparam logic [3:0] TickB = 4'(pSampleBase + 1);
   localparam logic [3:0] TickV = 4'(pSampleBase + SAMPLE_VOTE_OFS);

   logic [pSyncStages-1:0] sync_p;
   logic                   smp_p0;
   logic                   smp_p1;

   // Chain presets to idle-high so a reset never looks like a start edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p <= '1;
      end else begin
         sync_p <= {sync_p[pSyncStages-2:0], rxd};
      end
   end

   assign rx_sync = sync_p[pSyncStages-1];

   always_ff @(posedge clk) begin
      if (ce_16x && (phase == TickA)) smp_p0 <= rx_sync;
      if (ce_16x && (phase == TickB)) smp_p1 <= rx_sync;
   end

   assign smp_vld = ce_16x && (phase == TickV);
   assign smp_bit = maj3(smp_p0, smp_p1, rx_sync);

endmodule

// File: rtl/uart_rx_sm.sv
// UART receiver: 16x oversampled, 7/8 data bits, one-deep holding register with read handshake.
// Define UART_RX_PARITY_EN to add the ParEn/ParOdd inputs, the PE flag and the PAR state.
module uart_rx_sm
   import uart_pkg::*;
#(
   parameter int pSyncStages = 2,
   parameter int pSampleBase = SAMPLE_BASE
)
(
   input  logic       Clk,
   input  logic       Rst,
   input  logic       CE_16x,
   input  logic       RxD,
   input  logic       Len,
   input  logic       RdEn,
`ifdef UART_RX_PARITY_EN
   input  logic       ParEn,
   input  logic       ParOdd,
   output logic       PE,
`endif
   output logic [7:0] RxData,
   output logic       RxRdy,
   output logic       FE,
   output logic       OE,
   output logic       Brk,
   output logic       RxIdle
);

   logic [2:0] state;
   logic [3:0] phase;
   logic [3:0] bit_cnt;
   logic       len_q;
   logic [7:0] shreg;
   logic       rx_sync;
   logic       smp_vld;
   logic       smp_bit;
   logic       xfer;
   logic       load;
   logic       ovr;
   logic       pop;
   rx_frame_t  frame;
`ifdef UART_RX_PARITY_EN
   logic       par_q;
   logic       odd_q;
   logic       par_bit;
   logic       par_err;
`endif

   uart_rx_sync #(
      .pSyncStages (pSyncStages),
      .pSampleBase (pSampleBase)
   ) u_sync (
      .clk     (Clk),
      .rst     (Rst),
      .ce_16x  (CE_16x),
      .rxd     (RxD),
      .phase   (phase),
      .rx_sync (rx_sync),
      .smp_vld (smp_vld),
      .smp_bit (smp_bit)
   );

   // The detect tick itself counts as phase 0, so the register holds 1 on the tick after.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state   <= ST_IDLE;
         phase   <= 4'd0;
         bit_cnt <= 4'd0;
         len_q   <= LEN_8;
`ifdef UART_RX_PARITY_EN
         par_q   <= 1'b0;
         odd_q   <= 1'b0;
`endif
      end else if (CE_16x) begin
         phase <= phase + 4'd1;
         case (state)
            ST_IDLE: begin
               phase <= 4'd0;
               if (!rx_sync) begin
                  state <= ST_START;
                  phase <= 4'd1;
               end
            end
            ST_START: begin
               if (smp_vld) begin
                  if (!smp_bit) begin
                     state   <= ST_DATA;
                     bit_cnt <= 4'd0;
                     len_q   <= Len;
`ifdef UART_RX_PARITY_EN
                     par_q   <= ParEn;
                     odd_q   <= ParOdd;
`endif
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_DATA: begin
               if (smp_vld) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  if (bit_cnt == last_data_idx(len_q)) begin
`ifdef UART_RX_PARITY_EN
                     state <= state_after_data(par_q);
`else
                     state <= state_after_data(1'b0);
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PAR: begin
               if (smp_vld) state <= ST_STOP;
            end
`endif
            ST_STOP: begin
               if (smp_vld) state <= smp_bit ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
               if (rx_sync) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (smp_vld && (state == ST_DATA)) shreg <= {smp_bit, shreg[7:1]};
`ifdef UART_RX_PARITY_EN
      if (smp_vld && (state == ST_PAR)) par_bit <= smp_bit;
`endif
   end

   // In 7-bit mode the last seven shifts sit in shreg[7:1].
   always_comb begin
      frame      = '0;
      frame.data = (len_q == LEN_7) ? {1'b0, shreg[7:1]} : shreg;
      frame.fe   = ~smp_bit;
`ifdef UART_RX_PARITY_EN
      par_err    = 1'b0;
      frame.brk  = frame.fe && (frame.data == 8'h00) && !(par_q && par_bit);
      par_err    = par_q && ((^frame.data ^ par_bit) != odd_q);
`else
      frame.brk  = frame.fe && (frame.data == 8'h00);
`endif
   end

   assign xfer = smp_vld && (state == ST_STOP);
   assign load = xfer && (!RxRdy || RdEn);
   assign ovr  = xfer && RxRdy && !RdEn;
   assign pop  = RdEn && RxRdy && !xfer;

   always_ff @(posedge Clk) begin
      if (Rst) begin
         RxData <= 8'h00;
         RxRdy  <= 1'b0;
         FE     <= 1'b0;
         OE     <= 1'b0;
         Brk    <= 1'b0;
      end else if (ovr) begin
         OE <= 1'b1;
      end else if (load) begin
         RxData <= frame.data;
         RxRdy  <= 1'b1;
         FE     <= frame.fe;
         Brk    <= frame.brk;
         OE     <= 1'b0;
      end else if (pop) begin
         RxRdy <= 1'b0;
         FE    <= 1'b0;
         OE    <= 1'b0;
         Brk   <= 1'b0;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         PE <= 1'b0;
      end else if (load) begin
         PE <= par_err;
      end else if (pop) begin
         PE <= 1'b0;
      end
   end
`endif

   assign RxIdle = (state == ST_IDLE);

endmodule
